cache_arbiter: RTL and testbench

//  Shares one physical-memory line port between the instruction cache (port A

---
 rtl/cache_arbiter_pkg.sv | 29 ++
 rtl/cache_arbiter.sv | 144 ++++++++++++++
 tb/tb_cache_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1-to-memory line arbiter.
//   arb_state_t : arbiter FSM states
//   arb_grant_t : identity of the most recently granted requester
//   rv32i_word  : 32-bit machine word
//   sat_inc32   : saturating 32-bit increment used by event counters
package cache_arbiter_pkg;

    localparam int unsigned LINE_W_DEF = 256;
    localparam int unsigned ADDR_W_DEF = 32;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } arb_grant_t;

    // Holds at all-ones instead of wrapping to zero.
    function automatic rv32i_word sat_inc32(input rv32i_word v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one memory line port between the I-cache miss path
// and the D-cache miss/writeback path. One line transfer at a time, round-robin
// on simultaneous requests, request address/data/op latched at grant.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   i_read/i_address      I-cache line read request (held until i_resp)
//   i_rdata/i_resp        line data and one-cycle completion to I-cache
//   d_read/d_write        D-cache line read / writeback request (held until d_resp)
//   d_address/d_wdata     D-cache line address and writeback line
//   d_rdata/d_resp        line data and one-cycle completion to D-cache
//   mem_read/mem_write    memory strobes (never both high)
//   mem_address/mem_wdata latched transfer address and write line
//   mem_rdata/mem_resp    memory read line and completion pulse
//   contention            saturating count of cycles with both requesters asserting
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W = LINE_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [31:0]       contention
);

    arb_state_t        state;
    arb_state_t        state_next;
    arb_grant_t        last_grant;
    logic              i_req;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic              lat_write;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and grant decision; grants only happen from IDLE, so every
    // completion is followed by at least one IDLE cycle.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    if (last_grant == GRANT_D) grant_i = 1'b1;
                    else                       grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i)      state_next = SERVE_I;
                else if (grant_d) state_next = SERVE_D;
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs. A D request with both read and write set is served as a write.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (state)
            SERVE_I: begin
                mem_read = 1'b1;
                i_resp   = mem_resp;
            end
            SERVE_D: begin
                mem_read  = ~lat_write;
                mem_write = lat_write;
                d_resp    = mem_resp;
            end
            default: ;
        endcase
    end

    assign mem_address = lat_addr;
    assign mem_wdata   = lat_wdata;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

    // Request latches: captured on the grant edge, ignored thereafter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_D;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_write  <= 1'b0;
        end else if (grant_i) begin
            last_grant <= GRANT_I;
            lat_addr   <= i_address;
            lat_write  <= 1'b0;
        end else if (grant_d) begin
            last_grant <= GRANT_D;
            lat_addr   <= d_address;
            lat_wdata  <= d_wdata;
            lat_write  <= d_write;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contention <= '0;
        end else if (i_req && d_req) begin
            contention <= sat_inc32(contention);
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected line transfers are queued when
// requests are raised and checked when the memory model completes them.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;
    logic [31:0]   contention;

    always #5 clk = ~clk;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .contention(contention)
    );

    typedef struct packed {
        logic          is_d;
        logic          wr;
        logic [31:0]   addr;
        logic [255:0]  wdata;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned exp_cont = 0;
    bit          model_last_d = 1'b1;
    int unsigned mm_cnt = 0;
    int unsigned resp_no = 0;
    int unsigned mem_lat = 5;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: completes a strobed access mem_lat cycles after the strobe appears.
    initial begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mm_cnt   = 0;
                mem_resp = 1'b0;
                continue;
            end
            #1;
            if (mem_resp) begin
                mem_resp = 1'b0;
                mm_cnt   = 0;
            end else if (mem_read || mem_write) begin
                mm_cnt++;
                if (mm_cnt >= mem_lat) begin
                    resp_no++;
                    mem_rdata = {8{32'hC0DE_0000 + resp_no}};
                    mem_resp  = 1'b1;
                end
            end else begin
                mm_cnt = 0;
            end
        end
    end

    task automatic push(input logic is_d, input logic wr, input logic [31:0] addr, input logic [255:0] wd);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wd;
        sb.push_back(e);
    endtask

    task automatic req_i(input logic [31:0] addr);
        i_read    = 1'b1;
        i_address = addr;
        push(1'b0, 1'b0, addr, '0);
        model_last_d = 1'b0;
    endtask

    task automatic req_d(input logic rd, input logic wr, input logic [31:0] addr, input logic [255:0] wd);
        d_read    = rd;
        d_write   = wr;
        d_address = addr;
        d_wdata   = wd;
        push(1'b1, wr, addr, wd);
        model_last_d = 1'b1;
    endtask

    // Both requesters in the same cycle; the one not granted last goes first.
    task automatic req_both(input logic [31:0] ia, input logic rd, input logic wr,
                            input logic [31:0] da, input logic [255:0] wd);
        i_read    = 1'b1;
        i_address = ia;
        d_read    = rd;
        d_write   = wr;
        d_address = da;
        d_wdata   = wd;
        if (model_last_d) begin
            push(1'b0, 1'b0, ia, '0);
            push(1'b1, wr, da, wd);
        end else begin
            push(1'b1, wr, da, wd);
            push(1'b0, 1'b0, ia, '0);
        end
    endtask

    // Runs until every queued transfer has completed and requests are dropped.
    task automatic run(input int budget, input bit move_d);
        exp_t e;
        bit   drop_i;
        bit   drop_d;
        bit   moved = 1'b0;
        bit   do_move;
        int   cyc = 0;
        while (i_read || d_read || d_write || sb.size() != 0) begin
            if (cyc >= budget) begin
                check("timeout", 256'(1), 256'(0));
                i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
                sb.delete();
                break;
            end
            cyc++;
            @(negedge clk);
            if (i_read && (d_read || d_write)) exp_cont++;
            check("strobe_excl", 256'(mem_read & mem_write), 256'(0));
            drop_i  = 1'b0;
            drop_d  = 1'b0;
            do_move = move_d && !moved && mem_write;
            if (mem_resp) begin
                if (sb.size() == 0) begin
                    check("unexpected_xfer", 256'(1), 256'(0));
                end else begin
                    e = sb.pop_front();
                    check("i_resp", 256'(i_resp), 256'(!e.is_d));
                    check("d_resp", 256'(d_resp), 256'(e.is_d));
                    check("mem_address", 256'(mem_address), 256'(e.addr));
                    check("mem_read", 256'(mem_read), 256'(!e.wr));
                    check("mem_write", 256'(mem_write), 256'(e.wr));
                    if (e.wr)        check("mem_wdata", mem_wdata, e.wdata);
                    else if (e.is_d) check("d_rdata", d_rdata, mem_rdata);
                    else             check("i_rdata", i_rdata, mem_rdata);
                    drop_i = !e.is_d;
                    drop_d = e.is_d;
                end
            end else begin
                check("resp_quiet", 256'({i_resp, d_resp}), 256'(0));
            end
            @(posedge clk);
            #1;
            if (drop_i) i_read = 1'b0;
            if (drop_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
            if (do_move) begin
                d_address = 32'h0000_0300;
                d_wdata   = ~d_wdata;
                moved     = 1'b1;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        model_last_d = 1'b1;
        exp_cont     = 0;
    endtask

    initial begin
        bit seen;
        reset     = 1'b1;
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mem_read", 256'(mem_read), 256'(0));
        check("rst_mem_write", 256'(mem_write), 256'(0));
        check("rst_mem_address", 256'(mem_address), 256'(0));
        check("rst_contention", 256'(contention), 256'(0));

        // Reset in the middle of a writeback: everything drops immediately.
        @(posedge clk);
        #1;
        d_write   = 1'b1;
        d_address = 32'h0000_0400;
        d_wdata   = {8{32'hDEAD_BEEF}};
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = mem_write;
        end
        check("t1_write_started", 256'(mem_write), 256'(1));
        #1;
        reset = 1'b1;
        #1;
        check("t1_mem_write", 256'(mem_write), 256'(0));
        check("t1_mem_read", 256'(mem_read), 256'(0));
        check("t1_mem_address", 256'(mem_address), 256'(0));
        check("t1_mem_wdata", mem_wdata, '0);
        check("t1_resp", 256'({i_resp, d_resp}), 256'(0));
        d_write = 1'b0;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        model_last_d = 1'b1;
        exp_cont     = 0;
        @(negedge clk);
        check("t1_idle_after", 256'({mem_read, mem_write}), 256'(0));

        // Lone I-cache read: strobe and address appear the cycle after the grant edge.
        @(posedge clk);
        #1;
        req_i(32'h0000_0100);
        @(negedge clk);
        check("t2_no_strobe_yet", 256'(mem_read), 256'(0));
        @(negedge clk);
        check("t2_mem_read", 256'(mem_read), 256'(1));
        check("t2_mem_address", 256'(mem_address), 256'(32'h0000_0100));
        run(100, 1'b0);
        check("t2_contention", 256'(contention), 256'(exp_cont));

        // Simultaneous requests straight after reset: I first, then D writeback.
        pulse_reset();
        req_both(32'h0000_0180, 1'b0, 1'b1, 32'h0000_0200, {8{32'h1111_2222}});
        run(100, 1'b0);
        check("t3_contention", 256'(contention), 256'(exp_cont));

        // Back-to-back contended rounds: I, D, I, D.
        @(posedge clk);
        #1;
        req_both(32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000, '0);
        run(100, 1'b0);
        req_both(32'h0000_1040, 1'b0, 1'b1, 32'h0000_2040, {8{32'h3333_4444}});
        run(100, 1'b0);
        check("t4_contention", 256'(contention), 256'(exp_cont));

        // After a lone I grant, a contended round goes to D first.
        req_i(32'h0000_0600);
        run(100, 1'b0);
        req_both(32'h0000_0640, 1'b1, 1'b0, 32'h0000_0680, '0);
        run(100, 1'b0);
        check("t7_contention", 256'(contention), 256'(exp_cont));

        // Address and data changed after grant are ignored.
        req_d(1'b0, 1'b1, 32'h0000_0200, {8{32'h5555_6666}});
        run(100, 1'b1);

        // Read and write together is served as a write.
        req_d(1'b1, 1'b1, 32'h0000_0700, {8{32'h7777_8888}});
        run(100, 1'b0);

        // Plain D-cache read.
        req_d(1'b1, 1'b0, 32'h0000_0800, '0);
        run(100, 1'b0);

        @(negedge clk);
        check("final_idle", 256'({mem_read, mem_write}), 256'(0));
        check("final_contention", 256'(contention), 256'(exp_cont));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
